// File: rtl/updown_pkg.sv
// Shared encodings for the up/down step sequencer.
package updown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2,
        ST_LOCK      = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Hold/repeat interval counter: counts while run is high and flags the last
// cycle of the selected interval, restarting from zero on that cycle.
module step_timer #(
    parameter int DELAY_CYC = 62_500_000,
    parameter int RATE_CYC  = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sel_rate,
    output logic done
);

    localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW:0] DLY_T  = (TW+1)'(DELAY_CYC);
    localparam logic [TW:0] RATE_T = (TW+1)'(RATE_CYC);

    logic [TW-1:0] count;
    logic [TW:0]   count_inc;

    // One bit wider so the compare never sees a wrapped value.
    assign count_inc = {1'b0, count} + 1'b1;
    assign done      = count_inc >= (sel_rate ? RATE_T : DLY_T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!run || done)
            count <= '0;
        else if (count != '1)
            count <= count_inc[TW-1:0];
    end

endmodule

// File: rtl/updown_step_ctrl.sv
// Button-level to step-strobe sequencer: edge detect, hold-to-repeat,
// two-button lockout and limit gating in front of the up/down counter.
module updown_step_ctrl
    import updown_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 15,
    parameter int WRAP      = 0,
    parameter int DELAY_CYC = 62_500_000,
    parameter int RATE_CYC  = 12_500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_lvl,
    input  logic             down_lvl,
    input  logic [CNT_W-1:0] count_in,
    output logic             step_up,
    output logic             step_down,
    output logic             repeating,
    output logic             limit_hit
);

    state_t state_q, state_d;
    logic   dir_q, dir_d;
    logic   up_prev, down_prev;
    logic   up_rise, down_rise;
    logic   act_lvl, opp_lvl;
    logic   fire, at_limit;
    logic   tmr_run, tmr_done;

    assign up_rise   = up_lvl & ~up_prev;
    assign down_rise = down_lvl & ~down_prev;
    assign act_lvl   = (dir_q == DIR_UP) ? up_lvl : down_lvl;
    assign opp_lvl   = (dir_q == DIR_UP) ? down_lvl : up_lvl;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fire    = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (up_lvl && down_lvl) begin
                        state_d = ST_LOCK;
                    end else if (up_rise) begin
                        state_d = ST_HOLD_WAIT;
                        dir_d   = DIR_UP;
                        fire    = 1'b1;
                    end else if (down_rise) begin
                        state_d = ST_HOLD_WAIT;
                        dir_d   = DIR_DOWN;
                        fire    = 1'b1;
                    end
                end
                ST_HOLD_WAIT, ST_REPEAT: begin
                    // Release/opposite checks come first so they mask a due strobe.
                    if (opp_lvl)
                        state_d = ST_LOCK;
                    else if (!act_lvl)
                        state_d = ST_IDLE;
                    else if (tmr_done) begin
                        state_d = ST_REPEAT;
                        fire    = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!up_lvl && !down_lvl)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        at_limit = 1'b0;
        if (WRAP == 0) begin
            if (dir_d == DIR_UP)
                at_limit = (count_in == CNT_W'(MAX_VAL));
            else
                at_limit = (count_in == CNT_W'(MIN_VAL));
        end
    end

    // Timer restarts on every state change, so HOLD_WAIT->REPEAT begins a fresh interval.
    assign tmr_run = en && (state_d == state_q) &&
                     ((state_q == ST_HOLD_WAIT) || (state_q == ST_REPEAT));

    step_timer #(
        .DELAY_CYC (DELAY_CYC),
        .RATE_CYC  (RATE_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (tmr_run),
        .sel_rate (state_q == ST_REPEAT),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            up_prev   <= 1'b1;
            down_prev <= 1'b1;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            repeating <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            up_prev   <= up_lvl;
            down_prev <= down_lvl;
            step_up   <= fire && (dir_d == DIR_UP)   && !at_limit;
            step_down <= fire && (dir_d == DIR_DOWN) && !at_limit;
            limit_hit <= fire && at_limit;
            repeating <= (state_d == ST_REPEAT);
        end
    end

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Randomized level-trace bench for updown_step_ctrl with an episode-level
// reference model, a strobe scoreboard and a 4-bit counter closing the loop.
module tb_updown_step_ctrl;

    localparam int DLY = 8;
    localparam int RT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       up_lvl = 1'b1;
    logic       down_lvl = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic       step_up, step_down, repeating, limit_hit;

    always #5 clk = ~clk;

    updown_step_ctrl #(
        .CNT_W(4), .MIN_VAL(0), .MAX_VAL(15), .WRAP(0),
        .DELAY_CYC(DLY), .RATE_CYC(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .up_lvl(up_lvl), .down_lvl(down_lvl), .count_in(cnt),
        .step_up(step_up), .step_down(step_down),
        .repeating(repeating), .limit_hit(limit_hit)
    );

    // Stand-in for the 4-bit counter that consumes the strobes.
    always @(posedge clk) begin
        if (step_up)        cnt <= cnt + 4'd1;
        else if (step_down) cnt <= cnt - 4'd1;
    end

    typedef struct { int cyc; int kind; } ev_t;  // kind: 0 up, 1 down, 2 limit
    ev_t exp_q[$];
    bit  ub[$], db[$], eb[$];
    bit  exp_rep[];
    int  n_chk = 0, n_fail = 0;
    int  cur_edge = 0;
    bit  trace_on = 1'b0;
    int  mcnt = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cur_edge, act, req);
        end
    endtask

    task automatic seg(input bit u, input bit d, input bit e, input int len);
        repeat (len) begin
            ub.push_back(u); db.push_back(d); eb.push_back(e);
        end
    endtask

    function automatic bit uu(input int i);
        return (i < 0) ? 1'b1 : ub[i];
    endfunction
    function automatic bit dd(input int i);
        return (i < 0) ? 1'b1 : db[i];
    endfunction

    // A button step either moves the count or is refused at the rail.
    function automatic void emit(input int c, input int dir);
        ev_t ev;
        ev.cyc = c;
        if (dir == 0) begin
            if (mcnt == 15) ev.kind = 2; else begin ev.kind = 0; mcnt++; end
        end else begin
            if (mcnt == 0) ev.kind = 2; else begin ev.kind = 1; mcnt--; end
        end
        exp_q.push_back(ev);
    endfunction

    // Lockout lasts until both buttons are up or the enable drops.
    function automatic int lock_exit(input int s);
        int f = s + 1;
        while (f < ub.size() && eb[f] && (ub[f] || db[f])) f++;
        return f;
    endfunction

    function automatic void build_expect();
        int n = ub.size();
        int c = 0;
        exp_rep = new[n];
        foreach (exp_rep[i]) exp_rep[i] = 1'b0;
        while (c < n) begin
            int dir, e;
            bit a, o;
            if (!eb[c]) begin c++; continue; end
            if (ub[c] && db[c]) begin c = lock_exit(c) + 1; continue; end
            if (ub[c] && !uu(c-1))      dir = 0;
            else if (db[c] && !dd(c-1)) dir = 1;
            else begin c++; continue; end
            emit(c, dir);
            // Press held for k edges: strobes at k = DLY, DLY+RT, DLY+2RT, ...
            e = c + 1;
            while (e < n) begin
                a = dir ? db[e] : ub[e];
                o = dir ? ub[e] : db[e];
                if (!(eb[e] && a && !o)) break;
                if (e - c >= DLY) begin
                    exp_rep[e] = 1'b1;
                    if ((e - c - DLY) % RT == 0) emit(e, dir);
                end
                e++;
            end
            if (e >= n) c = n;
            else if (eb[e] && (dir ? ub[e] : db[e])) c = lock_exit(e) + 1;
            else c = e + 1;
        end
    endfunction

    // Scoreboard monitor for the trace phase.
    always @(posedge clk) begin
        int ka, ns;
        #1;
        if (trace_on) begin
            ns = int'(step_up) + int'(step_down) + int'(limit_hit);
            chk(ns <= 1, "one_strobe_per_cycle", ns, 1);
            ka = step_up ? 0 : step_down ? 1 : limit_hit ? 2 : -1;
            while (exp_q.size() > 0 && exp_q[0].cyc < cur_edge) begin
                chk(exp_q[0].cyc >= cur_edge, "missing_strobe_cycle", exp_q[0].cyc, cur_edge);
                void'(exp_q.pop_front());
            end
            if (ka >= 0) begin
                chk(exp_q.size() > 0, "unexpected_strobe", ka, -1);
                if (exp_q.size() > 0) begin
                    chk(exp_q[0].cyc == cur_edge && exp_q[0].kind == ka,
                        "strobe_kind_cycle", ka * 100000 + cur_edge,
                        exp_q[0].kind * 100000 + exp_q[0].cyc);
                    if (exp_q[0].cyc == cur_edge) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cur_edge) begin
                chk(ka == exp_q[0].kind, "missing_strobe", ka, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            chk(repeating == exp_rep[cur_edge], "repeating", int'(repeating), int'(exp_rep[cur_edge]));
        end
    end

    initial begin
        int nstrb;
        bit hit;

        // Trace: held-over-reset, tap, long hold, same-cycle both, limits,
        // overlap into lock, enable toggling, then random segments.
        seg(1,0,1,5);  seg(0,0,1,3);
        seg(1,0,1,3);  seg(0,0,1,4);
        seg(1,0,1,30); seg(0,0,1,3);
        seg(1,1,1,5);  seg(0,1,1,4); seg(0,0,1,3);
        seg(1,0,1,90); seg(0,0,1,3); seg(1,0,1,2); seg(0,0,1,3);
        seg(0,1,1,120); seg(0,0,1,2); seg(0,1,1,2); seg(0,0,1,3);
        seg(0,1,1,20); seg(1,1,1,6); seg(0,0,1,3);
        seg(1,0,1,6);  seg(1,0,0,3); seg(1,0,1,6); seg(0,0,1,2);
        seg(0,1,0,3);  seg(0,1,1,5); seg(0,0,1,2);
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 5);
            bit b = 1'($urandom_range(0, 1));
            case (k)
                0: seg(0,0,1,$urandom_range(1,5));
                1: seg(!b,b,1,$urandom_range(1,6));
                2: seg(!b,b,1,$urandom_range(8,30));
                3: seg(1,1,1,$urandom_range(1,5));
                4: begin seg(!b,b,1,$urandom_range(3,20)); seg(1,1,1,$urandom_range(2,4)); end
                default: seg(!b,b,0,$urandom_range(1,6));
            endcase
            seg(0,0,1,$urandom_range(1,3));
        end
        build_expect();

        #3;
        chk({step_up,step_down,repeating,limit_hit} == 4'b0, "reset_outputs",
            int'({step_up,step_down,repeating,limit_hit}), 0);
        repeat (3) @(negedge clk);
        chk({step_up,step_down,repeating,limit_hit} == 4'b0, "reset_outputs_clocked",
            int'({step_up,step_down,repeating,limit_hit}), 0);

        rst_n = 1'b1;
        trace_on = 1'b1;
        for (int c = 0; c < ub.size(); c++) begin
            if (c > 0) @(negedge clk);
            up_lvl = ub[c]; down_lvl = db[c]; en = eb[c];
            cur_edge = c;
        end
        @(posedge clk); #2;
        trace_on = 1'b0;
        chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);

        // Reset asserted in the middle of auto-repeat.
        @(negedge clk); up_lvl = 0; down_lvl = 0; en = 1;
        repeat (3) @(negedge clk);
        up_lvl = 1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin @(posedge clk); #1; hit = repeating; end
        chk(hit, "reach_repeat", int'(hit), 1);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin @(posedge clk); #1; hit = step_up | limit_hit; end
        chk(hit, "repeat_strobe_seen", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk({step_up,step_down,repeating,limit_hit} == 4'b0, "async_reset_clears",
            int'({step_up,step_down,repeating,limit_hit}), 0);
        @(negedge clk); rst_n = 1'b1;
        nstrb = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            nstrb += int'(step_up) + int'(step_down) + int'(limit_hit) + int'(repeating);
        end
        chk(nstrb == 0, "held_through_reset_no_step", nstrb, 0);
        @(negedge clk); up_lvl = 0;
        repeat (2) @(negedge clk);
        up_lvl = 1;
        @(posedge clk); #1;
        chk(step_up | limit_hit, "repress_steps", int'(step_up | limit_hit), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
